pixel_cfg_writer: RTL and testbench

Pixel-array configuration write engine. Sits between the SPI configuration register decoder and the pixel matrix. It turns each SPI config request (address, data, valid) into a timed one-hot pixel write strobe: `pixel_sel` plus `pixel_wdata`, then a `pixel_wren` pulse. A one-entry pending buffer absorbs a request that arrives while a write is in progress. Out-of-range addresses and overflows are flagged.

---
 rtl/pixel_cfg_writer.sv | 190 +++++++++++++++++++
 tb/tb_pixel_cfg_writer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_cfg_writer.sv
// rtl/pixel_cfg_writer.sv - SPI config request to timed one-hot pixel write strobe engine
module pixel_cfg_writer #(
  parameter int NUM_PIXELS = 180,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 15,
  parameter int SETUP_CYC  = 1,
  parameter int WR_CYC     = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                  sys_clock,
  input  logic                  sys_resetn,
  input  logic [ADDR_W-1:0]     spi_cfg_addr,
  input  logic [DATA_W-1:0]     spi_cfg_data,
  input  logic                  spi_cfg_valid,
  output logic [NUM_PIXELS-1:0] pixel_sel,
  output logic [DATA_W-1:0]     pixel_wdata,
  output logic                  pixel_wren,
  output logic                  cfg_busy,
  output logic                  cfg_addr_err,
  output logic                  cfg_overflow,
  output logic [15:0]           wr_count
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0]      SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]      WR_LAST    = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0]      HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [ADDR_W:0]       NUM_PIX_L  = (ADDR_W + 1)'(NUM_PIXELS);
  localparam logic [NUM_PIXELS-1:0] SEL_ONE    = NUM_PIXELS'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_WRITE, ST_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    valid_q;
  logic [NUM_PIXELS-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    wren_q, wren_d;
  logic                    pend_full_q, pend_full_d;
  logic [ADDR_W-1:0]       pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0]       pend_data_q, pend_data_d;
  logic                    err_q, err_d;
  logic                    ovf_q, ovf_d;
  logic [15:0]             count_q, count_d;
  logic                    req;
  logic                    req_taken;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NUM_PIX_L;
  endfunction

  // A request is the rising edge of spi_cfg_valid.
  assign req = spi_cfg_valid & ~valid_q;

  // Next-state logic: phase sequencing, pending pop/push, error flags.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    wren_d      = wren_q;
    pend_full_d = pend_full_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    err_d       = 1'b0;
    ovf_d       = 1'b0;
    count_d     = count_q;
    req_taken   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_taken = 1'b1;
        if (req) begin
          if (addr_ok(spi_cfg_addr)) begin
            state_d = ST_SETUP;
            cnt_d   = '0;
            sel_d   = SEL_ONE << spi_cfg_addr;
            wdata_d = spi_cfg_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
          wren_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (cnt_q == WR_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          wren_d  = 1'b0;
          count_d = count_q + 16'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          sel_d   = '0;
          // Pending entry is popped before any same-edge request is looked at.
          if (pend_full_q) begin
            pend_full_d = 1'b0;
            if (addr_ok(pend_addr_q)) begin
              state_d = ST_SETUP;
              sel_d   = SEL_ONE << pend_addr_q;
              wdata_d = pend_data_q;
            end else begin
              err_d = 1'b1;
            end
          end
          // Engine is free again: a same-edge request launches directly.
          if (state_d == ST_IDLE) begin
            req_taken = 1'b1;
            if (req) begin
              if (addr_ok(spi_cfg_addr)) begin
                state_d = ST_SETUP;
                sel_d   = SEL_ONE << spi_cfg_addr;
                wdata_d = spi_cfg_data;
              end else begin
                err_d = 1'b1;
              end
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Requests arriving mid-write go to the pending buffer, or are dropped.
    if (req && !req_taken) begin
      if (!pend_full_d) begin
        pend_full_d = 1'b1;
        pend_addr_d = spi_cfg_addr;
        pend_data_d = spi_cfg_data;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State and output registers; valid_q resets high so a held valid is not a request.
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      valid_q     <= 1'b1;
      sel_q       <= '0;
      wdata_q     <= '0;
      wren_q      <= 1'b0;
      pend_full_q <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= spi_cfg_valid;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      wren_q      <= wren_d;
      pend_full_q <= pend_full_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
    end
  end

  assign pixel_sel    = sel_q;
  assign pixel_wdata  = wdata_q;
  assign pixel_wren   = wren_q;
  assign cfg_busy     = (state_q != ST_IDLE) | pend_full_q;
  assign cfg_addr_err = err_q;
  assign cfg_overflow = ovf_q;
  assign wr_count     = count_q;

endmodule

// File: tb/tb_pixel_cfg_writer.sv
// tb/tb_pixel_cfg_writer.sv - randomized self-checking bench for pixel_cfg_writer
module tb_pixel_cfg_writer;

  localparam int N = 180;
  localparam int S = 1;
  localparam int W = 2;
  localparam int H = 1;
  localparam int P = S + W + H;

  logic          sys_clock = 1'b0;
  logic          sys_resetn;
  logic [7:0]    spi_cfg_addr;
  logic [14:0]   spi_cfg_data;
  logic          spi_cfg_valid;
  logic [N-1:0]  pixel_sel;
  logic [14:0]   pixel_wdata;
  logic          pixel_wren;
  logic          cfg_busy;
  logic          cfg_addr_err;
  logic          cfg_overflow;
  logic [15:0]   wr_count;

  int n_tests;
  int n_fail;

  pixel_cfg_writer #(
    .NUM_PIXELS(N), .ADDR_W(8), .DATA_W(15),
    .SETUP_CYC(S), .WR_CYC(W), .HOLD_CYC(H)
  ) dut (
    .sys_clock     (sys_clock),
    .sys_resetn    (sys_resetn),
    .spi_cfg_addr  (spi_cfg_addr),
    .spi_cfg_data  (spi_cfg_data),
    .spi_cfg_valid (spi_cfg_valid),
    .pixel_sel     (pixel_sel),
    .pixel_wdata   (pixel_wdata),
    .pixel_wren    (pixel_wren),
    .cfg_busy      (cfg_busy),
    .cfg_addr_err  (cfg_addr_err),
    .cfg_overflow  (cfg_overflow),
    .wr_count      (wr_count)
  );

  always #5 sys_clock = ~sys_clock;

  // Transaction-level reference: one active write (age in edges since launch) plus one pending slot.
  bit          m_active;
  int          m_age;
  int          m_addr;
  logic [14:0] m_wdata;
  bit          m_pend;
  int          m_pa;
  logic [14:0] m_pd;
  logic [15:0] m_count;
  bit          m_prev_v;
  bit          m_err;
  bit          m_ovf;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_age = 0; m_addr = 0; m_wdata = '0;
    m_pend = 0; m_pa = 0; m_pd = '0; m_count = '0;
    m_prev_v = 1; m_err = 0; m_ovf = 0;
  endfunction

  function automatic void model_launch(input int a, input logic [14:0] d);
    m_active = 1; m_age = 0; m_addr = a; m_wdata = d;
  endfunction

  // One rising clock edge with the given request inputs.
  function automatic void model_edge(input bit v, input int a, input logic [14:0] d);
    bit req;
    req = v && !m_prev_v;
    m_prev_v = v;
    m_err = 0;
    m_ovf = 0;
    if (m_active) begin
      m_age++;
      if (m_age == S + W) m_count++;
      if (m_age == P) begin
        m_active = 0;
        if (m_pend) begin
          m_pend = 0;
          if (m_pa < N) model_launch(m_pa, m_pd);
          else m_err = 1;
        end
      end
    end
    if (req) begin
      if (m_active) begin
        if (!m_pend) begin m_pend = 1; m_pa = a; m_pd = d; end
        else m_ovf = 1;
      end else if (a < N) begin
        model_launch(a, d);
      end else begin
        m_err = 1;
      end
    end
  endfunction

  task automatic compare_all();
    logic [N-1:0] one;
    logic [N-1:0] exp_sel;
    one = 1;
    exp_sel = m_active ? (one << m_addr) : '0;
    chk("sel", pixel_sel, exp_sel);
    chk("wren", pixel_wren, m_active && m_age >= S && m_age < S + W);
    chk("wdata", pixel_wdata, m_wdata);
    chk("busy", cfg_busy, m_active || m_pend);
    chk("addr_err", cfg_addr_err, m_err);
    chk("overflow", cfg_overflow, m_ovf);
    chk("wr_count", wr_count, m_count);
  endtask

  // Drive at the falling edge, advance the model across the rising edge, check at the next falling edge.
  task automatic step(input bit v, input int a, input logic [14:0] d);
    spi_cfg_valid = v;
    spi_cfg_addr  = 8'(a);
    spi_cfg_data  = d;
    model_edge(v, a, d);
    @(negedge sys_clock);
    compare_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (m_active || m_pend); i++) step(0, 0, '0);
    step(0, 0, '0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    sys_resetn    = 1'b0;
    spi_cfg_valid = 1'b0;
    spi_cfg_addr  = '0;
    spi_cfg_data  = '0;
    model_reset();
    #1 compare_all();
    @(negedge sys_clock);
    @(negedge sys_clock);
    sys_resetn = 1'b1;

    // Single write.
    step(1, 5, 15'h1234);
    for (int i = 0; i < 6; i++) step(0, 5, 15'h1234);

    // Out-of-range addresses.
    step(1, 180, 15'h0aaa); step(0, 0, '0);
    step(1, 255, 15'h0555); step(0, 0, '0);
    step(0, 0, '0);

    // Pending buffer fill, back-to-back pop, overflow.
    for (int i = 1; i <= 4; i++) begin
      step(1, i, 15'(16'h100 + i));
      step(0, 0, '0);
    end
    drain();

    // Sweep every pixel.
    for (int a = 0; a < N; a++) begin
      step(1, a, 15'(a));
      step(0, 0, '0);
      drain();
    end

    // Reset in the WRITE phase with valid held high through release.
    step(1, 20, 15'h2222);
    step(0, 20, 15'h2222);
    spi_cfg_valid = 1'b1;
    sys_resetn = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge sys_clock);
    sys_resetn = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 9, 15'h0999);
    step(0, 9, 15'h0999);
    step(1, 9, 15'h0999);
    drain();

    // wr_count wrap.
    force dut.count_q = 16'hffff;
    m_count = 16'hffff;
    step(0, 0, '0);
    release dut.count_q;
    step(1, 7, 15'h7777);
    drain();

    // Random traffic, including illegal addresses, pending pops and overflows.
    for (int i = 0; i < 4000; i++) begin
      int a;
      a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(180, 255)) : int'($urandom_range(0, 179));
      step(bit'($urandom_range(0, 1)), a, 15'($urandom));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
